d0_fifo_reader: RTL and testbench
=================================

// Module: d0_fifo_reader
// PURPOSE
//  Read-side controller for the D0 lane FIFO. Watches the FIFO empty/error flags, drives the FIFO
//  read enable, absorbs the FIFO's 1-cycle registered read latency in a small skid buffer, and presents
//  words downstream on a valid/ready handshake. Sits between the D0 FIFO output and the next stage.
// PARAMETERS
//  DATA_WIDTH   6  width of FIFO word / data_out
//  SKID_DEPTH   2  skid buffer entries (>=2 required for full throughput)
//  CNT_WIDTH    8  width of forwarded-word counter
// PORTS
//  clk             in   1           single clock, all logic on rising edge
//  reset_L         in   1           asynchronous, active-low reset
//  init            in   1           0 = hold block in INIT (synchronous clear), 1 = run
//  fifo_empty      in   1           FIFO empty flag
//  fifo_error      in   1           FIFO error flag
//  fifo_data       in   DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_enable
//  fifo_rd_enable  out  1           FIFO read strobe (combinational)
//  ready_in        in   1           downstream accepts data_out this cycle
//  valid_out       out  1           data_out holds a valid word
//  data_out        out  DATA_WIDTH  head of skid buffer; 0 when valid_out=0
//  idle_out        out  1           ACTIVE, FIFO empty, skid empty, no read pending
//  error_out       out  1           sticky, set in ERROR state
//  word_count      out  CNT_WIDTH   words accepted downstream since INIT
//  state_out       out  2           RESET=00 INIT=01 ACTIVE=10 ERROR=11
// BEHAVIOUR
//  - reset_L=0 (async, any time): state=RESET, skid/pending/count cleared; outputs fifo_rd_enable=0,
//    valid_out=0, data_out=0, idle_out=0, error_out=0, word_count=0. In-flight read is discarded.
//  - FSM: RESET -> INIT on first edge with reset_L=1. INIT -> ACTIVE when init=1. Any state -> INIT on
//    edge with init=0 (clears skid, pending, word_count, error_out). ACTIVE -> ERROR on edge with
//    fifo_error=1. ERROR holds until init=0. fifo_rd_enable=0 and valid_out=0 in every state but ACTIVE.
//  - pop = valid_out & ready_in. rd_pending = registered fifo_rd_enable of previous cycle.
//  - fifo_rd_enable = ACTIVE & !fifo_empty & !fifo_error & (skid_cnt + rd_pending - pop) < SKID_DEPTH.
//  - When rd_pending=1, fifo_data is written into skid tail on that edge (same edge as any pop).
//  - valid_out = ACTIVE & (skid_cnt != 0); data_out = skid head. FIFO->data_out latency: 2 cycles
//    from fifo_rd_enable edge (read edge, then capture edge) with empty skid.
//  - Full throughput: ready_in held 1 and FIFO non-empty -> one word per cycle, no bubbles.
//  - ready_in=0: valid_out and data_out held stable; reads stop once skid+pending reaches SKID_DEPTH.
//    Skid never overflows; overflow is a design error (assertion in bench).
//  - Simultaneous capture and pop: skid_cnt unchanged, order preserved (FIFO order, no reordering).
//  - Skid pointers wrap modulo SKID_DEPTH.
//  - word_count += 1 per pop, wraps 2**CNT_WIDTH-1 -> 0 silently.
//  - init=0 mid-transfer: pending read discarded, skid contents dropped, next ACTIVE starts empty.
//  - ERROR entered with pending read: capture is discarded.
// TESTING
//  1 Reset: reset_L=0 asynchronously mid-cycle with skid holding 2 words -> all outputs 0 immediately,
//    state_out=00; after release and init=1, state_out 01 -> 10.
//  2 Streaming: FIFO preloaded 0x01..0x04, ready_in=1 -> fifo_rd_enable 4 consecutive cycles,
//    data_out 0x01,0x02,0x03,0x04 on consecutive cycles starting 2 cycles after first read, word_count=4,
//    idle_out=1 afterwards.
//  3 Backpressure: FIFO holds 4 words, ready_in=0 -> exactly 2 reads, valid_out=1, data_out=0x01 stable;
//    ready_in=1 -> remaining words delivered in order, no loss/duplication.
//  4 Single-word edge: FIFO holds 1 word -> single fifo_rd_enable pulse; no read issued while
//    fifo_empty=1; idle_out=1 after pop.
//  5 Error: assert fifo_error during streaming -> state_out=11, error_out=1, fifo_rd_enable=0,
//    valid_out=0; init=0 then 1 -> error_out=0, word_count=0, state ACTIVE.
//  6 Counter wrap: CNT_WIDTH=2, deliver 5 words -> word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/d0_fifo_reader.sv
// -----------------------------------------------------------------------------
// d0_fifo_reader
// Read-side controller for the D0 lane FIFO. Issues FIFO reads while there is
// room downstream, absorbs the FIFO's one-cycle registered read latency in a
// small skid buffer, and presents words to the next stage on valid/ready.
//
// Ports
//   clk             single clock, rising edge
//   reset_L         asynchronous active-low reset
//   init            0 = hold in INIT with everything cleared, 1 = run
//   fifo_empty      FIFO empty flag
//   fifo_error      FIFO error flag
//   fifo_data       FIFO read data, valid one cycle after fifo_rd_enable
//   fifo_rd_enable  FIFO read strobe (combinational)
//   ready_in        downstream accepts data_out this cycle
//   valid_out       data_out holds a valid word
//   data_out        head of the skid buffer, 0 when valid_out = 0
//   idle_out        ACTIVE with FIFO empty, skid empty and no read in flight
//   error_out       sticky error flag, set on entry to ERROR, cleared by init=0
//   word_count      words accepted downstream since INIT (wraps)
//   state_out       FSM state: RESET=00 INIT=01 ACTIVE=10 ERROR=11
//
// Handshake: a word transfers on every rising edge where valid_out and
// ready_in are both 1. While valid_out=1 and ready_in=0, valid_out and
// data_out hold their values; valid_out never drops without a transfer
// except on reset, init=0 or entry to ERROR.
// -----------------------------------------------------------------------------
module d0_fifo_reader #(
   parameter int DATA_WIDTH = 6,
   parameter int SKID_DEPTH = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  init,
   input  logic                  fifo_empty,
   input  logic                  fifo_error,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_enable,
   input  logic                  ready_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  idle_out,
   output logic                  error_out,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic [1:0]            state_out
);

   localparam int PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int SCNT_W = $clog2(SKID_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_RESET  = 2'b00,
      ST_INIT   = 2'b01,
      ST_ACTIVE = 2'b10,
      ST_ERROR  = 2'b11
   } state_t;

   state_t                state, state_next;
   logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
   logic [PTR_W-1:0]      head, tail;
   logic [SCNT_W-1:0]     skid_cnt;
   logic                  rd_pending;
   logic                  err_q;
   logic [CNT_WIDTH-1:0]  count;
   logic                  active, pop, capture, rd_en;
   logic [SCNT_W:0]       occupancy;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_RESET:  state_next = ST_INIT;
         ST_INIT:   if (init) state_next = ST_ACTIVE;
         ST_ACTIVE: begin
            if (!init)           state_next = ST_INIT;
            else if (fifo_error) state_next = ST_ERROR;
         end
         ST_ERROR:  if (!init) state_next = ST_INIT;
         default:   state_next = ST_INIT;
      endcase
   end

   // Datapath control
   always_comb begin
      active    = (state == ST_ACTIVE);
      valid_out = active && (skid_cnt != '0);
      pop       = valid_out && ready_in;
      // Entries committed after this edge: held words plus the read in flight,
      // minus the word leaving now. A new read is only issued if it has a slot.
      occupancy = {1'b0, skid_cnt} + (SCNT_W+1)'(rd_pending) - (SCNT_W+1)'(pop);
      rd_en     = active && !fifo_empty && !fifo_error &&
                  (occupancy < (SCNT_W+1)'(SKID_DEPTH));
      // A read landing as the block leaves ACTIVE is dropped.
      capture   = rd_pending && active && (state_next == ST_ACTIVE);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state      <= ST_RESET;
         head       <= '0;
         tail       <= '0;
         skid_cnt   <= '0;
         rd_pending <= 1'b0;
         err_q      <= 1'b0;
         count      <= '0;
      end else begin
         state <= state_next;
         if (!init) begin
            head       <= '0;
            tail       <= '0;
            skid_cnt   <= '0;
            rd_pending <= 1'b0;
            err_q      <= 1'b0;
            count      <= '0;
         end else begin
            rd_pending <= rd_en;
            if (capture) tail <= ptr_inc(tail);
            if (pop)     head <= ptr_inc(head);
            case ({capture, pop})
               2'b10:   skid_cnt <= skid_cnt + SCNT_W'(1);
               2'b01:   skid_cnt <= skid_cnt - SCNT_W'(1);
               default: skid_cnt <= skid_cnt;
            endcase
            if (pop) count <= count + CNT_WIDTH'(1);
            if (state_next == ST_ERROR) err_q <= 1'b1;
         end
      end
   end

   // Skid storage needs no reset: entries are only visible through skid_cnt.
   always_ff @(posedge clk) begin
      if (capture) skid_mem[tail] <= fifo_data;
   end

   assign fifo_rd_enable = rd_en;
   assign data_out       = valid_out ? skid_mem[head] : '0;
   assign idle_out       = active && fifo_empty && (skid_cnt == '0) && !rd_pending;
   assign error_out      = err_q;
   assign word_count     = count;
   assign state_out      = state;

endmodule

// File: tb/tb_d0_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_d0_fifo_reader
// Directed bench for d0_fifo_reader. A behavioural FIFO with a one-cycle
// registered read feeds two instances: the default build and a CNT_WIDTH=2
// build used for the word counter wrap. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_d0_fifo_reader;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       init;
   logic       fifo_error;
   logic       ready_in;
   logic [5:0] fifo_data;
   logic       fifo_empty;

   logic       rd_en, valid, idle, err;
   logic [5:0] data;
   logic [7:0] wc;
   logic [1:0] st;

   logic       rd_en2, valid2, idle2, err2;
   logic [5:0] data2;
   logic [1:0] wc2;
   logic [1:0] st2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural FIFO: preloaded from the stimulus, read data registered.
   logic [5:0] fifo_mem [64];
   int         wr_ptr = 0;
   int         rd_ptr = 0;

   assign fifo_empty = (rd_ptr == wr_ptr);

   initial fifo_data = '0;
   always @(posedge clk) begin
      if (rd_en && rd_ptr != wr_ptr) begin
         fifo_data <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   d0_fifo_reader u_dut (
      .clk(clk), .reset_L(reset_L), .init(init),
      .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data(fifo_data),
      .fifo_rd_enable(rd_en), .ready_in(ready_in), .valid_out(valid),
      .data_out(data), .idle_out(idle), .error_out(err),
      .word_count(wc), .state_out(st)
   );

   d0_fifo_reader #(.CNT_WIDTH(2)) u_dut2 (
      .clk(clk), .reset_L(reset_L), .init(init),
      .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data(fifo_data),
      .fifo_rd_enable(rd_en2), .ready_in(ready_in), .valid_out(valid2),
      .data_out(data2), .idle_out(idle2), .error_out(err2),
      .word_count(wc2), .state_out(st2)
   );

   task automatic preload(input logic [5:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         fifo_mem[wr_ptr] = first + 6'(i);
         wr_ptr = wr_ptr + 1;
      end
   endtask

   // Pulse init low for one cycle; returns on the falling edge with the DUT ACTIVE.
   task automatic do_init();
      @(negedge clk);
      init = 1'b0; ready_in = 1'b1; fifo_error = 1'b0;
      @(negedge clk);
      init = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_L = 1'b1; init = 1'b0; ready_in = 1'b0; fifo_error = 1'b0;
      #1 reset_L = 1'b0;
      @(negedge clk); #1;
      checks++; if (st !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", st); end
      checks++; if ({rd_en, valid, data, idle, err, wc} !== '0) begin errors++;
         $display("FAIL reset_outputs got rd=%b v=%b d=%h idle=%b err=%b wc=%0d exp all 0", rd_en, valid, data, idle, err, wc); end
      @(negedge clk);
      reset_L = 1'b1; init = 1'b1;
      @(negedge clk); #1;
      checks++; if (st !== 2'b01) begin errors++; $display("FAIL reset_to_init got=%b exp=01", st); end
      @(negedge clk); #1;
      checks++; if (st !== 2'b10) begin errors++; $display("FAIL init_to_active got=%b exp=10", st); end
      // Fill the skid with two words under backpressure, then reset mid-cycle.
      preload(6'h31, 2);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (valid !== 1'b1 || data !== 6'h31) begin errors++;
         $display("FAIL reset_prefill got v=%b d=%h exp v=1 d=31", valid, data); end
      #2 reset_L = 1'b0;
      #1;
      checks++; if (st !== 2'b00) begin errors++; $display("FAIL async_reset_state got=%b exp=00", st); end
      checks++; if ({rd_en, valid, data, idle, err, wc} !== '0) begin errors++;
         $display("FAIL async_reset_outputs got rd=%b v=%b d=%h idle=%b err=%b wc=%0d exp all 0", rd_en, valid, data, idle, err, wc); end
      @(negedge clk);
      reset_L = 1'b1;
      @(negedge clk); #1;
      checks++; if (st !== 2'b01) begin errors++; $display("FAIL rerelease_init got=%b exp=01", st); end
      @(negedge clk); #1;
      checks++; if (st !== 2'b10 || valid !== 1'b0 || idle !== 1'b1) begin errors++;
         $display("FAIL rerelease_active got st=%b v=%b idle=%b exp st=10 v=0 idle=1", st, valid, idle); end
   endtask

   task automatic test_streaming();
      logic       exp_rd [7] = '{1, 1, 1, 1, 0, 0, 0};
      logic       exp_v  [7] = '{0, 0, 1, 1, 1, 1, 0};
      logic [5:0] exp_d  [7] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h00};
      do_init();
      preload(6'h01, 4);
      for (int c = 0; c < 7; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         checks++; if (rd_en !== exp_rd[c]) begin errors++; $display("FAIL stream_rd c%0d got=%b exp=%b", c, rd_en, exp_rd[c]); end
         checks++; if (valid !== exp_v[c]) begin errors++; $display("FAIL stream_valid c%0d got=%b exp=%b", c, valid, exp_v[c]); end
         checks++; if (data !== exp_d[c]) begin errors++; $display("FAIL stream_data c%0d got=%h exp=%h", c, data, exp_d[c]); end
      end
      checks++; if (wc !== 8'd4) begin errors++; $display("FAIL stream_count got=%0d exp=4", wc); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stream_idle got=%b exp=1", idle); end
   endtask

   task automatic test_backpressure();
      int         reads = 0;
      logic       exp_rd [5] = '{1, 1, 0, 0, 0};
      logic       exp_v  [5] = '{1, 1, 1, 1, 0};
      logic [5:0] exp_d  [5] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h00};
      do_init();
      ready_in = 1'b0;
      preload(6'h01, 4);
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         if (rd_en === 1'b1) reads++;
         if (c >= 2) begin
            checks++; if (valid !== 1'b1 || data !== 6'h01) begin errors++;
               $display("FAIL bp_hold c%0d got v=%b d=%h exp v=1 d=01", c, valid, data); end
         end
      end
      checks++; if (reads != 2) begin errors++; $display("FAIL bp_reads got=%0d exp=2", reads); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         ready_in = 1'b1;
         #1;
         checks++; if (rd_en !== exp_rd[c]) begin errors++; $display("FAIL bp_rd c%0d got=%b exp=%b", c, rd_en, exp_rd[c]); end
         checks++; if (valid !== exp_v[c] || data !== exp_d[c]) begin errors++;
            $display("FAIL bp_drain c%0d got v=%b d=%h exp v=%b d=%h", c, valid, data, exp_v[c], exp_d[c]); end
      end
      checks++; if (wc !== 8'd4 || idle !== 1'b1) begin errors++;
         $display("FAIL bp_end got wc=%0d idle=%b exp wc=4 idle=1", wc, idle); end
   endtask

   task automatic test_single_word();
      logic       exp_rd   [4] = '{1, 0, 0, 0};
      logic       exp_v    [4] = '{0, 0, 1, 0};
      logic [5:0] exp_d    [4] = '{6'h00, 6'h00, 6'h2A, 6'h00};
      logic       exp_idle [4] = '{0, 0, 0, 1};
      do_init();
      for (int c = 0; c < 3; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         checks++; if (rd_en !== 1'b0 || idle !== 1'b1) begin errors++;
            $display("FAIL empty_no_read c%0d got rd=%b idle=%b exp rd=0 idle=1", c, rd_en, idle); end
      end
      @(negedge clk);
      preload(6'h2A, 1);
      for (int c = 0; c < 4; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         checks++; if (rd_en !== exp_rd[c]) begin errors++; $display("FAIL single_rd c%0d got=%b exp=%b", c, rd_en, exp_rd[c]); end
         checks++; if (valid !== exp_v[c] || data !== exp_d[c]) begin errors++;
            $display("FAIL single_data c%0d got v=%b d=%h exp v=%b d=%h", c, valid, data, exp_v[c], exp_d[c]); end
         checks++; if (idle !== exp_idle[c]) begin errors++; $display("FAIL single_idle c%0d got=%b exp=%b", c, idle, exp_idle[c]); end
      end
      checks++; if (wc !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", wc); end
   endtask

   task automatic test_error();
      do_init();
      preload(6'h05, 4);
      for (int c = 0; c < 12; c++) begin
         if (c != 0) @(negedge clk);
         if (c == 3) fifo_error = 1'b1;
         if (c == 4) fifo_error = 1'b0;
         if (c == 6) init = 1'b0;
         if (c == 7) init = 1'b1;
         #1;
         case (c)
            2: begin
               checks++; if (valid !== 1'b1 || data !== 6'h05) begin errors++;
                  $display("FAIL err_pre got v=%b d=%h exp v=1 d=05", valid, data); end
            end
            3: begin
               checks++; if (rd_en !== 1'b0 || st !== 2'b10) begin errors++;
                  $display("FAIL err_flag_cycle got rd=%b st=%b exp rd=0 st=10", rd_en, st); end
            end
            4, 5: begin
               checks++; if (st !== 2'b11 || err !== 1'b1) begin errors++;
                  $display("FAIL err_state c%0d got st=%b err=%b exp st=11 err=1", c, st, err); end
               checks++; if (rd_en !== 1'b0 || valid !== 1'b0 || data !== 6'h00) begin errors++;
                  $display("FAIL err_quiet c%0d got rd=%b v=%b d=%h exp 0", c, rd_en, valid, data); end
               if (c == 4) begin
                  checks++; if (wc !== 8'd2) begin errors++; $display("FAIL err_count got=%0d exp=2", wc); end
               end
            end
            7: begin
               checks++; if (st !== 2'b01 || err !== 1'b0 || wc !== 8'd0) begin errors++;
                  $display("FAIL err_clear got st=%b err=%b wc=%0d exp st=01 err=0 wc=0", st, err, wc); end
            end
            8: begin
               checks++; if (st !== 2'b10 || rd_en !== 1'b1) begin errors++;
                  $display("FAIL err_resume got st=%b rd=%b exp st=10 rd=1", st, rd_en); end
            end
            10: begin
               checks++; if (valid !== 1'b1 || data !== 6'h08) begin errors++;
                  $display("FAIL err_discard got v=%b d=%h exp v=1 d=08", valid, data); end
            end
            11: begin
               checks++; if (idle !== 1'b1 || err !== 1'b0 || wc !== 8'd1) begin errors++;
                  $display("FAIL err_after got idle=%b err=%b wc=%0d exp idle=1 err=0 wc=1", idle, err, wc); end
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_count_wrap();
      logic [1:0] exp_wc2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_init();
      preload(6'h09, 5);
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         if (c >= 3) begin
            checks++; if (wc2 !== exp_wc2[c-3]) begin errors++;
               $display("FAIL wrap_count c%0d got=%0d exp=%0d", c, wc2, exp_wc2[c-3]); end
         end
      end
      checks++; if (wc !== 8'd5) begin errors++; $display("FAIL wrap_wide_count got=%0d exp=5", wc); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_single_word();
      test_error();
      test_count_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
